// File: rtl/regs_wb_pkg.sv
// Shared types and constants for the register-file writeback block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regs_wb_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    ERROR     = 2'd2
  } wb_state_t;

  // RV32I load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/regs_writeback_if.sv
// Execute handshake, memory response and register-file write port bundle.
// Latency: n/a (wiring only).
// Backpressure: wb_ready from the writeback side stalls execute.
interface regs_writeback_if;
  import regs_wb_pkg::*;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 wb_is_load;
  logic [2:0]           wb_funct3;
  logic [XLEN-1:0]      wb_result;
  logic                 mem_rvalid;
  logic [XLEN-1:0]      mem_rdata;
  logic [REG_IDX_W-1:0] reg_write_select;
  logic [XLEN-1:0]      reg_write_data;
  logic                 reg_write_control;
  logic                 busy;
  logic                 timeout_err;

  // Writeback block side
  modport slave (
    input  wb_valid, wb_rd, wb_is_load, wb_funct3, wb_result,
    input  mem_rvalid, mem_rdata,
    output wb_ready, reg_write_select, reg_write_data, reg_write_control,
    output busy, timeout_err
  );

  // Execute / memory / environment side
  modport master (
    output wb_valid, wb_rd, wb_is_load, wb_funct3, wb_result,
    output mem_rvalid, mem_rdata,
    input  wb_ready, reg_write_select, reg_write_data, reg_write_control,
    input  busy, timeout_err
  );

endinterface

// File: rtl/regs_writeback_load_extract.sv
// Selects the loaded byte/halfword from an aligned word and extends it.
// Latency: combinational.
// Backpressure: none.
module load_extract
  import regs_wb_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select; halfwords use only offset[1], misalignment is not trapped here
  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Width/sign handling; reserved codes fall back to a full word
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'h000000, w_byte};
      F3_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/regs_writeback.sv
// Drives the register-file write port from execute results and load responses.
// Latency: 1 cycle after accept (ALU) or after mem_rvalid (load).
// Backpressure: wb_ready only in IDLE; a pending load or a timeout stalls execute.
module regs_writeback
  import regs_wb_pkg::*;
#(
  parameter int XLEN        = regs_wb_pkg::XLEN,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  regs_writeback_if.slave  bus
);

  localparam logic [16:0] LP_TMO = 17'(MEM_TIMEOUT);

  wb_state_t            r_state;
  wb_state_t            w_state_nxt;
  logic [15:0]          r_cnt;
  logic [REG_IDX_W-1:0] r_rd;
  logic [2:0]           r_funct3;
  logic [1:0]           r_off;
  logic                 r_err;

  logic                 r_wr_en;
  logic [REG_IDX_W-1:0] r_wr_sel;
  logic [XLEN-1:0]      r_wr_data;

  logic                 w_wr_en;
  logic [REG_IDX_W-1:0] w_wr_sel;
  logic [XLEN-1:0]      w_wr_data;

  logic                 w_accept;
  logic                 w_timeout;
  logic [XLEN-1:0]      w_ext;

  assign w_accept  = bus.wb_valid && (r_state == IDLE);
  // Fires in the last allowed WAIT_LOAD cycle; rvalid in that cycle still wins
  assign w_timeout = (({1'b0, r_cnt} + 17'd1) == LP_TMO);

  load_extract u_load_extract (
    .i_rdata  (bus.mem_rdata),
    .i_funct3 (r_funct3),
    .i_offset (r_off),
    .o_data   (w_ext)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; ERROR is only left through reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_accept && bus.wb_is_load) w_state_nxt = WAIT_LOAD;
      WAIT_LOAD: begin
        if (bus.mem_rvalid)  w_state_nxt = IDLE;
        else if (w_timeout)  w_state_nxt = ERROR;
      end
      default:   w_state_nxt = ERROR;
    endcase
  end

  // Next write-port values; x0 is never written, select/data hold otherwise
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_sel  = r_wr_sel;
    w_wr_data = r_wr_data;
    case (r_state)
      IDLE: begin
        if (w_accept && !bus.wb_is_load && (bus.wb_rd != '0)) begin
          w_wr_en   = 1'b1;
          w_wr_sel  = bus.wb_rd;
          w_wr_data = bus.wb_result;
        end
      end
      WAIT_LOAD: begin
        if (bus.mem_rvalid && (r_rd != '0)) begin
          w_wr_en   = 1'b1;
          w_wr_sel  = r_rd;
          w_wr_data = w_ext;
        end
      end
      default: ;
    endcase
  end

  // Registered write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en   <= 1'b0;
      r_wr_sel  <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= w_wr_en;
      r_wr_sel  <= w_wr_sel;
      r_wr_data <= w_wr_data;
    end
  end

  // Pending-load context, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd     <= '0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept && bus.wb_is_load) begin
        r_rd     <= bus.wb_rd;
        r_funct3 <= bus.wb_funct3;
        r_off    <= bus.wb_result[1:0];
        r_cnt    <= '0;
      end else if (r_state == WAIT_LOAD) begin
        r_cnt <= r_cnt + 16'd1;
        if (!bus.mem_rvalid && w_timeout) r_err <= 1'b1;
      end
    end
  end

  assign bus.wb_ready          = (r_state == IDLE);
  assign bus.busy              = (r_state != IDLE);
  assign bus.timeout_err       = r_err;
  assign bus.reg_write_control = r_wr_en;
  assign bus.reg_write_select  = r_wr_sel;
  assign bus.reg_write_data    = r_wr_data;

endmodule

// File: tb/tb_regs_writeback.sv
// Self-checking bench for regs_writeback with a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_regs_writeback;

  localparam int TMO = 4;

  logic clk;
  logic reset;
  regs_writeback_if bus();

  regs_writeback #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 accepting, 1 load outstanding, 2 dead after timeout
  typedef struct {
    int          phase;
    logic        ctrl;
    logic [4:0]  sel;
    logic [31:0] data;
    logic [4:0]  prd;
    logic [2:0]  pf3;
    logic [1:0]  poff;
    int          deadline;
    logic        err;
  } mdl_t;

  mdl_t m;
  int   cyc;

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.phase = 0; r.ctrl = 0; r.sel = 0; r.data = 0;
    r.prd = 0; r.pf3 = 0; r.poff = 0; r.deadline = 0; r.err = 0;
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int                 hsh;
    hsh = off[1] ? 16 : 0;
    sb  = 8'(w >> (8 * off));
    sh  = 16'(w >> hsh);
    case (f3)
      3'b000:  return 32'(int'(sb));
      3'b001:  return 32'(int'(sh));
      3'b100:  return (w >> (8 * off)) & 32'h0000_00FF;
      3'b101:  return (w >> hsh) & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic mdl_t mdl_step(input mdl_t cur, input int c);
    mdl_t n;
    n = cur;
    n.ctrl = 0;
    if (cur.phase == 0) begin
      if (bus.wb_valid) begin
        if (bus.wb_is_load) begin
          n.phase = 1; n.prd = bus.wb_rd; n.pf3 = bus.wb_funct3;
          n.poff = bus.wb_result[1:0]; n.deadline = c + TMO;
        end else if (bus.wb_rd != 0) begin
          n.ctrl = 1; n.sel = bus.wb_rd; n.data = bus.wb_result;
        end
      end
    end else if (cur.phase == 1) begin
      if (bus.mem_rvalid) begin
        n.phase = 0;
        if (cur.prd != 0) begin
          n.ctrl = 1; n.sel = cur.prd; n.data = extract(bus.mem_rdata, cur.pf3, cur.poff);
        end
      end else if (c == cur.deadline) begin
        n.phase = 2; n.err = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m <= mdl_rst();
    end else begin
      m   <= mdl_step(m, cyc);
      cyc <= cyc + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ctrl", {31'd0, bus.reg_write_control}, {31'd0, m.ctrl});
    chk("ready", {31'd0, bus.wb_ready}, {31'd0, m.phase == 0});
    chk("busy", {31'd0, bus.busy}, {31'd0, m.phase != 0});
    chk("terr", {31'd0, bus.timeout_err}, {31'd0, m.err});
    if (m.ctrl) begin
      chk("sel", {27'd0, bus.reg_write_select}, {27'd0, m.sel});
      chk("data", bus.reg_write_data, m.data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    bus.wb_valid = 0; bus.wb_is_load = 0; bus.wb_rd = 0; bus.wb_funct3 = 0;
    bus.wb_result = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ctrl"}, {31'd0, bus.reg_write_control}, 32'd0);
    chk({nm, "_sel"}, {27'd0, bus.reg_write_select}, 32'd0);
    chk({nm, "_data"}, bus.reg_write_data, 32'd0);
    chk({nm, "_ready"}, {31'd0, bus.wb_ready}, 32'd1);
    chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, "_terr"}, {31'd0, bus.timeout_err}, 32'd0);
  endtask

  // Load with rvalid 'gap' cycles after the first WAIT_LOAD cycle
  task automatic do_load(input string nm, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] rdata, input int gap,
                         input logic [31:0] exp_data);
    bus.wb_valid = 1; bus.wb_is_load = 1; bus.wb_rd = rd; bus.wb_funct3 = f3;
    bus.wb_result = 32'h0000_1000 | {30'd0, off};
    tick();
    bus.wb_valid = 0; bus.wb_is_load = 0;
    for (int i = 0; i < gap; i++) begin
      chk({nm, "_wait_ready"}, {31'd0, bus.wb_ready}, 32'd0);
      chk({nm, "_wait_busy"}, {31'd0, bus.busy}, 32'd1);
      tick();
    end
    bus.mem_rvalid = 1; bus.mem_rdata = rdata;
    tick();
    bus.mem_rvalid = 0;
    if (rd != 0) begin
      chk({nm, "_ctrl"}, {31'd0, bus.reg_write_control}, 32'd1);
      chk({nm, "_sel"}, {27'd0, bus.reg_write_select}, {27'd0, rd});
      chk({nm, "_data"}, bus.reg_write_data, exp_data);
      chk({nm, "_model"}, m.data, exp_data);
    end else begin
      chk({nm, "_ctrl"}, {31'd0, bus.reg_write_control}, 32'd0);
    end
    chk({nm, "_ready_after"}, {31'd0, bus.wb_ready}, 32'd1);
    tick();
  endtask

  initial begin
    cyc = 0;
    clr_in();
    reset = 0;
    #1;
    chk_reset_vals("rst");
    tick();
    tick();
    reset = 1;
    #1;
    chk_reset_vals("rst_rel");
    tick();

    // Back-to-back ALU writes
    bus.wb_valid = 1; bus.wb_is_load = 0; bus.wb_rd = 5; bus.wb_result = 32'h1234_5678;
    tick();
    chk("b2b_ctrl0", {31'd0, bus.reg_write_control}, 32'd1);
    chk("b2b_sel0", {27'd0, bus.reg_write_select}, 32'd5);
    chk("b2b_data0", bus.reg_write_data, 32'h1234_5678);
    chk("b2b_ready0", {31'd0, bus.wb_ready}, 32'd1);
    bus.wb_rd = 6; bus.wb_result = 32'hDEAD_BEEF;
    tick();
    bus.wb_valid = 0;
    chk("b2b_ctrl1", {31'd0, bus.reg_write_control}, 32'd1);
    chk("b2b_sel1", {27'd0, bus.reg_write_select}, 32'd6);
    chk("b2b_data1", bus.reg_write_data, 32'hDEAD_BEEF);
    chk("b2b_model1", m.data, 32'hDEAD_BEEF);
    tick();
    chk("b2b_ctrl_drop", {31'd0, bus.reg_write_control}, 32'd0);

    // ALU write to x0
    bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_result = 32'hFFFF_FFFF;
    tick();
    bus.wb_valid = 0;
    chk("x0_alu_ctrl", {31'd0, bus.reg_write_control}, 32'd0);
    tick();

    // Load to x0
    do_load("x0_load", 5'd0, 3'b010, 2'd0, 32'h1111_2222, 1, 32'h0);

    // Extraction cases
    do_load("lb3",  5'd10, 3'b000, 2'd3, 32'h80FF_0011, 0, 32'hFFFF_FF80);
    do_load("lbu3", 5'd11, 3'b100, 2'd3, 32'h80FF_0011, 0, 32'h0000_0080);
    do_load("lh2",  5'd12, 3'b001, 2'd2, 32'h80FF_0011, 0, 32'hFFFF_80FF);
    do_load("lhu2", 5'd13, 3'b101, 2'd2, 32'h80FF_0011, 0, 32'h0000_80FF);
    do_load("lb0",  5'd14, 3'b000, 2'd0, 32'h80FF_0011, 0, 32'h0000_0011);
    do_load("lw",   5'd15, 3'b010, 2'd1, 32'h80FF_0011, 0, 32'h80FF_0011);
    do_load("f3_7", 5'd16, 3'b111, 2'd2, 32'h80FF_0011, 0, 32'h80FF_0011);
    do_load("lh3",  5'd17, 3'b001, 2'd3, 32'h7F00_1234, 0, 32'h0000_7F00);

    // Stray rvalid in IDLE, then a delayed response
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hAAAA_AAAA;
    tick();
    bus.mem_rvalid = 0;
    chk("stray_ctrl", {31'd0, bus.reg_write_control}, 32'd0);
    tick();
    do_load("delay", 5'd7, 3'b010, 2'd0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

    // Timeout without rvalid
    bus.wb_valid = 1; bus.wb_is_load = 1; bus.wb_rd = 8; bus.wb_funct3 = 3'b010;
    bus.wb_result = 32'h2000;
    tick();
    bus.wb_valid = 0; bus.wb_is_load = 0;
    repeat (3) tick();
    chk("tmo_pre_err", {31'd0, bus.timeout_err}, 32'd0);
    tick();
    chk("tmo_err", {31'd0, bus.timeout_err}, 32'd1);
    chk("tmo_ready", {31'd0, bus.wb_ready}, 32'd0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h5555_5555;
    tick();
    bus.mem_rvalid = 0;
    chk("tmo_late_ctrl", {31'd0, bus.reg_write_control}, 32'd0);
    chk("tmo_sticky", {31'd0, bus.timeout_err}, 32'd1);
    tick();
    reset = 0;
    #1;
    chk("tmo_rst_terr", {31'd0, bus.timeout_err}, 32'd0);
    chk("tmo_rst_ready", {31'd0, bus.wb_ready}, 32'd1);
    tick();
    reset = 1;
    tick();

    // rvalid in the last allowed cycle wins over the timeout
    do_load("tmo_edge", 5'd20, 3'b010, 2'd0, 32'h0BAD_CAFE, TMO - 1, 32'h0BAD_CAFE);
    chk("tmo_edge_terr", {31'd0, bus.timeout_err}, 32'd0);

    // Reset in the middle of a load
    bus.wb_valid = 1; bus.wb_is_load = 1; bus.wb_rd = 9; bus.wb_funct3 = 3'b010;
    bus.wb_result = 32'h3000;
    tick();
    bus.wb_valid = 0; bus.wb_is_load = 0;
    reset = 0;
    #1;
    chk_reset_vals("midrst");
    tick();
    reset = 1;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h9999_9999;
    tick();
    bus.mem_rvalid = 0;
    chk("midrst_ctrl", {31'd0, bus.reg_write_control}, 32'd0);
    chk("midrst_ready", {31'd0, bus.wb_ready}, 32'd1);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
